// File: rtl/herzel_regs_axil.sv
// AXI4-Lite control/status register file for the Goertzel (Herzel) engine.
// Independent read/write channels, per-channel result snapshots, W1C done flags and a maskable irq.
module herzel_regs_axil #(
    parameter int          NF      = 11,
    parameter logic [31:0] FREQ_BA = 32'h1000_0000,
    parameter logic [31:0] DATA_BA = 32'h2000_0000,
    parameter logic [31:0] VERSION = 32'h2904_2023
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          s_awaddr,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [31:0]          s_wdata,
    input  logic [3:0]           s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [31:0]          s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [31:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [NF-1:0][31:0]  freq_arr_o,
    input  logic [NF-1:0][31:0]  data_arr_i,
    input  logic                 valid_angel_i,
    input  logic                 valid_cordic_i,
    input  logic [NF-1:0]        valid_herzel_i,
    output logic [31:0]          num_samp_o,
    output logic [31:0]          samp_freq_o,
    output logic                 mode_o,
    output logic                 en_cordic_o,
    output logic                 reset_all_o,
    output logic                 reset_h_o,
    output logic                 irq_o
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] A_VERSION   = 32'h00;
    localparam logic [31:0] A_DEBUG     = 32'h04;
    localparam logic [31:0] A_MODE      = 32'h08;
    localparam logic [31:0] A_NUM_SAMP  = 32'h0C;
    localparam logic [31:0] A_SAMP_FREQ = 32'h10;
    localparam logic [31:0] A_EN_CORDIC = 32'h14;
    localparam logic [31:0] A_STATUS    = 32'h18;
    localparam logic [31:0] A_CONTROL   = 32'h1C;
    localparam logic [31:0] A_DONE      = 32'h20;
    localparam logic [31:0] A_IRQ_EN    = 32'h24;

    typedef enum logic [1:0] {W_ADDR_DATA, W_DATA, W_ADDR, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = strb_mask(s);
        return (old_v & ~m) | (new_v & m);
    endfunction

    wstate_t              wstate_q;
    rstate_t              rstate_q;
    logic                 awready_q, wready_q, bvalid_q, commit_q;
    logic [1:0]           bresp_q;
    logic [31:0]          awaddr_q, wdata_q;
    logic [3:0]           wstrb_q;
    logic                 arready_q, rvalid_q;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [31:0]          debug_q, num_samp_q, samp_freq_q;
    logic                 mode_q, en_cordic_q;
    logic [NF-1:0]        done_q, done_d, irq_en_q, prev_q, rise, done_clr;
    logic [NF-1:0][31:0]  freq_q, data_q;
    logic                 reset_all_q, reset_h_q, irq_q;

    logic                 aw_hs, w_hs, ar_hs, wr_err, wr_en;
    logic [31:0]          woff, roff_f, roff_d;
    logic [NF-1:0]        wr_freq_sel;

    assign aw_hs = s_awvalid && awready_q;
    assign w_hs  = s_wvalid && wready_q;
    assign ar_hs = s_arvalid && arready_q;

    always_comb begin
        woff        = awaddr_q - FREQ_BA;
        wr_freq_sel = '0;
        for (int i = 0; i < NF; i++) wr_freq_sel[i] = (woff == 32'(4 * i));
        case (awaddr_q)
            A_DEBUG, A_MODE, A_NUM_SAMP, A_SAMP_FREQ, A_EN_CORDIC,
            A_CONTROL, A_DONE, A_IRQ_EN: wr_err = 1'b0;
            default:                     wr_err = ~|wr_freq_sel;
        endcase
    end

    assign wr_en = commit_q && !wr_err;

    // A new rising edge on valid_herzel sets DONE even if a W1C clears it in the same cycle.
    always_comb begin
        rise     = valid_herzel_i & ~prev_q;
        done_clr = '0;
        for (int i = 0; i < NF; i++)
            done_clr[i] = wr_en && (awaddr_q == A_DONE) && wdata_q[i] && wstrb_q[i / 8];
        done_d = (done_q & ~done_clr) | rise;
    end

    always_comb begin
        roff_f  = s_araddr - FREQ_BA;
        roff_d  = s_araddr - DATA_BA;
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        case (s_araddr)
            A_VERSION:   rdata_d = VERSION;
            A_DEBUG:     rdata_d = debug_q;
            A_MODE:      rdata_d[0] = mode_q;
            A_NUM_SAMP:  rdata_d = num_samp_q;
            A_SAMP_FREQ: rdata_d = samp_freq_q;
            A_EN_CORDIC: rdata_d[0] = en_cordic_q;
            A_STATUS: begin
                rdata_d[0] = valid_angel_i;
                rdata_d[1] = valid_cordic_i;
                rdata_d[3] = &valid_herzel_i;
            end
            A_DONE:      rdata_d[NF-1:0] = done_q;
            A_IRQ_EN:    rdata_d[NF-1:0] = irq_en_q;
            default: begin
                rresp_d = RESP_SLVERR;
                for (int i = 0; i < NF; i++) begin
                    if (roff_f == 32'(4 * i)) begin
                        rdata_d = freq_q[i];
                        rresp_d = RESP_OKAY;
                    end else if (roff_d == 32'(4 * i)) begin
                        rdata_d = data_q[i];
                        rresp_d = RESP_OKAY;
                    end
                end
            end
        endcase
        if (rresp_d != RESP_OKAY) rdata_d = '0;
    end

    // Write channel: capture AW and W in either order, commit one cycle later with bvalid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= W_ADDR_DATA;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            commit_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            commit_q <= 1'b0;
            if (aw_hs) awaddr_q <= s_awaddr;
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            case (wstate_q)
                W_ADDR_DATA: begin
                    awready_q <= !aw_hs;
                    wready_q  <= !w_hs;
                    if (aw_hs && w_hs) begin
                        wstate_q <= W_RESP;
                        commit_q <= 1'b1;
                    end else if (aw_hs) begin
                        wstate_q <= W_DATA;
                    end else if (w_hs) begin
                        wstate_q <= W_ADDR;
                    end
                end
                W_DATA: if (w_hs) begin
                    wready_q <= 1'b0;
                    wstate_q <= W_RESP;
                    commit_q <= 1'b1;
                end
                W_ADDR: if (aw_hs) begin
                    awready_q <= 1'b0;
                    wstate_q  <= W_RESP;
                    commit_q  <= 1'b1;
                end
                W_RESP: begin
                    if (commit_q) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end else if (bvalid_q && s_bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_ADDR_DATA;
                    end
                end
                default: wstate_q <= W_ADDR_DATA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= !ar_hs;
                    if (ar_hs) begin
                        rstate_q <= R_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rdata_d;
                        rresp_q  <= rresp_d;
                    end
                end
                R_DATA: if (s_rready) begin
                    rstate_q  <= R_IDLE;
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            debug_q     <= 32'hF0F0_F0F0;
            mode_q      <= 1'b0;
            num_samp_q  <= 32'h0001_86A0;
            samp_freq_q <= 32'h0003_0D40;
            en_cordic_q <= 1'b0;
            irq_en_q    <= '0;
            freq_q      <= '0;
            data_q      <= '0;
            done_q      <= '0;
            prev_q      <= '0;
            reset_all_q <= 1'b0;
            reset_h_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            prev_q      <= valid_herzel_i;
            done_q      <= done_d;
            irq_q       <= |(done_q & irq_en_q);
            reset_all_q <= wr_en && (awaddr_q == A_CONTROL) && wstrb_q[0] && wdata_q[0];
            reset_h_q   <= wr_en && (awaddr_q == A_CONTROL) && wstrb_q[0] && wdata_q[1];
            for (int i = 0; i < NF; i++) begin
                if (rise[i]) data_q[i] <= data_arr_i[i];
                if (wr_en && wr_freq_sel[i]) freq_q[i] <= merge(freq_q[i], wdata_q, wstrb_q);
                if (wr_en && (awaddr_q == A_IRQ_EN) && wstrb_q[i / 8]) irq_en_q[i] <= wdata_q[i];
            end
            if (wr_en) begin
                case (awaddr_q)
                    A_DEBUG:     debug_q     <= merge(debug_q, wdata_q, wstrb_q);
                    A_NUM_SAMP:  num_samp_q  <= merge(num_samp_q, wdata_q, wstrb_q);
                    A_SAMP_FREQ: samp_freq_q <= merge(samp_freq_q, wdata_q, wstrb_q);
                    A_MODE:      if (wstrb_q[0]) mode_q <= wdata_q[0];
                    A_EN_CORDIC: if (wstrb_q[0]) en_cordic_q <= wdata_q[0];
                    default: ;
                endcase
            end
        end
    end

    assign s_awready   = awready_q;
    assign s_wready    = wready_q;
    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_arready   = arready_q;
    assign s_rvalid    = rvalid_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign freq_arr_o  = freq_q;
    assign num_samp_o  = num_samp_q;
    assign samp_freq_o = samp_freq_q;
    assign mode_o      = mode_q;
    assign en_cordic_o = en_cordic_q;
    assign reset_all_o = reset_all_q;
    assign reset_h_o   = reset_h_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_herzel_regs_axil.sv
// Directed bench for herzel_regs_axil: register map, handshakes, W1C/irq, control pulses, reset abort.
module tb_herzel_regs_axil;
    localparam int NF = 11;

    logic                clk = 1'b0;
    logic                rstn;
    logic [31:0]         s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]          s_wstrb;
    logic                s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]          s_bresp, s_rresp;
    logic                s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NF-1:0][31:0] freq_arr_o, data_arr_i;
    logic                valid_angel_i, valid_cordic_i;
    logic [NF-1:0]       valid_herzel_i;
    logic [31:0]         num_samp_o, samp_freq_o;
    logic                mode_o, en_cordic_o, reset_all_o, reset_h_o, irq_o;

    int n_vec = 0;
    int n_err = 0;
    int cnt_all = 0;
    int cnt_h = 0;

    herzel_regs_axil #(.NF(NF)) dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .freq_arr_o(freq_arr_o), .data_arr_i(data_arr_i),
        .valid_angel_i(valid_angel_i), .valid_cordic_i(valid_cordic_i),
        .valid_herzel_i(valid_herzel_i),
        .num_samp_o(num_samp_o), .samp_freq_o(samp_freq_o),
        .mode_o(mode_o), .en_cordic_o(en_cordic_o),
        .reset_all_o(reset_all_o), .reset_h_o(reset_h_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_all_o) cnt_all++;
        if (reset_h_o)   cnt_h++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp);
        int  t;
        bit  aw_h, w_h;
        @(negedge clk);
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
        t = 0;
        while ((s_awvalid || s_wvalid) && t < 50) begin
            aw_h = s_awvalid && s_awready;
            w_h  = s_wvalid && s_wready;
            @(negedge clk);
            if (aw_h) s_awvalid = 1'b0;
            if (w_h)  s_wvalid = 1'b0;
            t++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        t = 0;
        while (!s_bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bvalid_wait", {31'b0, s_bvalid}, 32'd1);
        resp = s_bresp;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int t;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        t = 0;
        while (!s_arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs, bs;
    int          lat;

    initial begin
        rstn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        data_arr_i = '0; valid_angel_i = 1'b0; valid_cordic_i = 1'b0; valid_herzel_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", {29'b0, s_awready, s_wready, s_arready}, 32'd0);
        chk("rst_valid", {30'b0, s_bvalid, s_rvalid}, 32'd0);
        chk("rst_resp", {28'b0, s_bresp, s_rresp}, 32'd0);
        chk("rst_pulse_irq", {29'b0, reset_all_o, reset_h_o, irq_o}, 32'd0);
        chk("rst_num_samp", num_samp_o, 32'h0001_86A0);
        chk("rst_samp_freq", samp_freq_o, 32'h0003_0D40);

        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);

        axi_write(32'h0C, 32'h0000_1234, 4'hF, bs);
        chk("num_samp_bresp", {30'b0, bs}, 32'd0);
        chk("num_samp_o", num_samp_o, 32'h0000_1234);
        axi_read(32'h0C, rd, rs, lat);
        chk("num_samp_rd", rd, 32'h0000_1234);
        chk("num_samp_rresp", {30'b0, rs}, 32'd0);
        chk("rd_latency", lat, 32'd1);
        axi_read(32'h00, rd, rs, lat);
        chk("version_rd", rd, 32'h2904_2023);
        axi_read(32'h04, rd, rs, lat);
        chk("debug_rst_rd", rd, 32'hF0F0_F0F0);
        axi_write(32'h04, 32'h1234_5678, 4'h4, bs);
        axi_read(32'h04, rd, rs, lat);
        chk("debug_strb_rd", rd, 32'hF034_F0F0);

        // W beat three cycles ahead of AW, response held off by bready
        @(negedge clk);
        s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'h3; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        s_awaddr = 32'h1000_0008; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int i = 0; i < 10 && !s_bvalid; i++) @(negedge clk);
        chk("w_first_bvalid", {31'b0, s_bvalid}, 32'd1);
        chk("w_first_freq2", freq_arr_o[2], 32'h0000_BEEF);
        repeat (5) @(negedge clk);
        chk("bvalid_hold", {30'b0, s_bvalid, s_awready}, 32'd2);
        chk("bresp_hold", {30'b0, s_bresp}, 32'd0);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        chk("bvalid_drop", {31'b0, s_bvalid}, 32'd0);

        axi_write(32'h1000_002C, 32'hFFFF_FFFF, 4'hF, bs);
        chk("err_wr_freq_nf", {30'b0, bs}, 32'd2);
        axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, bs);
        chk("err_wr_status", {30'b0, bs}, 32'd2);
        axi_write(32'h0D, 32'hFFFF_FFFF, 4'hF, bs);
        chk("err_wr_misalign", {30'b0, bs}, 32'd2);
        chk("err_no_side_effect", num_samp_o, 32'h0000_1234);
        axi_read(32'h1C, rd, rs, lat);
        chk("err_rd_control", {rd[29:0], rs}, 32'd2);
        axi_read(32'h3000_0000, rd, rs, lat);
        chk("err_rd_unmapped", {rd[29:0], rs}, 32'd2);
        axi_read(32'h02, rd, rs, lat);
        chk("err_rd_misalign", {rd[29:0], rs}, 32'd2);
        axi_read(32'h1000_0028, rd, rs, lat);
        chk("freq_last_rd", {rd[29:0], rs}, 32'd0);
        axi_read(32'h1000_0008, rd, rs, lat);
        chk("freq2_rd", rd, 32'h0000_BEEF);

        axi_write(32'h24, 32'h0000_0004, 4'hF, bs);
        @(negedge clk);
        data_arr_i[2] = 32'h55; valid_herzel_i[2] = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_set", {31'b0, irq_o}, 32'd1);
        axi_read(32'h2000_0008, rd, rs, lat);
        chk("snap_rd", rd, 32'h55);
        axi_read(32'h20, rd, rs, lat);
        chk("done_rd", rd, 32'h4);

        // W1C committing in the same cycle as a fresh rising edge
        valid_herzel_i[2] = 1'b0;
        repeat (2) @(negedge clk);
        s_awaddr = 32'h20; s_wdata = 32'h4; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        data_arr_i[2] = 32'h66; valid_herzel_i[2] = 1'b1;
        @(negedge clk);
        chk("w1c_race_bvalid", {31'b0, s_bvalid}, 32'd1);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        axi_read(32'h20, rd, rs, lat);
        chk("w1c_race_done", rd, 32'h4);
        chk("w1c_race_irq", {31'b0, irq_o}, 32'd1);
        axi_read(32'h2000_0008, rd, rs, lat);
        chk("snap2_rd", rd, 32'h66);
        axi_write(32'h20, 32'h4, 4'hF, bs);
        repeat (2) @(negedge clk);
        chk("w1c_irq_clr", {31'b0, irq_o}, 32'd0);
        axi_read(32'h20, rd, rs, lat);
        chk("w1c_done_clr", rd, 32'h0);

        axi_write(32'h1C, 32'h3, 4'hF, bs);
        repeat (2) @(negedge clk);
        chk("ctrl_pulse_cnt", {cnt_all[15:0], cnt_h[15:0]}, {16'd1, 16'd1});
        axi_write(32'h1C, 32'h0, 4'hF, bs);
        repeat (2) @(negedge clk);
        chk("ctrl_zero_nopulse", {cnt_all[15:0], cnt_h[15:0]}, {16'd1, 16'd1});

        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, bs);
        chk("mode_o", {31'b0, mode_o}, 32'd1);
        axi_read(32'h08, rd, rs, lat);
        chk("mode_rd_narrow", rd, 32'd1);
        axi_write(32'h14, 32'h1, 4'h2, bs);
        chk("en_cordic_masked", {31'b0, en_cordic_o}, 32'd0);
        axi_write(32'h14, 32'h1, 4'h1, bs);
        chk("en_cordic_set", {31'b0, en_cordic_o}, 32'd1);

        valid_angel_i = 1'b1; valid_herzel_i = '1;
        repeat (2) @(negedge clk);
        axi_read(32'h18, rd, rs, lat);
        chk("status_rd", rd, 32'h9);
        axi_read(32'h20, rd, rs, lat);
        chk("done_multi", rd, 32'h7FB);
        chk("irq_masked", {31'b0, irq_o}, 32'd0);
        axi_write(32'h24, 32'h7FF, 4'hF, bs);
        repeat (2) @(negedge clk);
        chk("irq_unmasked", {31'b0, irq_o}, 32'd1);

        // Reset asserted while a write response is pending
        @(negedge clk);
        s_awaddr = 32'h04; s_wdata = 32'h0; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 10 && !s_bvalid; i++) @(negedge clk);
        chk("pre_rst_bvalid", {31'b0, s_bvalid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_bvalid", {31'b0, s_bvalid}, 32'd0);
        chk("rst_num_samp2", num_samp_o, 32'h0001_86A0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_freq2", freq_arr_o[2], 32'd0);
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(32'h04, rd, rs, lat);
        chk("rst_debug_rd", rd, 32'hF0F0_F0F0);
        axi_read(32'h0C, rd, rs, lat);
        chk("rst_num_samp_rd", rd, 32'h0001_86A0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/herzel_regs_axil.md
Name: herzel_regs_axil

Overview:
Parametrised AXI4-Lite control/status register file for the Goertzel (Herzel) engine, replacing the single-FSM register block. It provides independent read and write channels with AW/W accepted in any order, byte strobes, and SLVERR decode. It also adds per-channel result snapshots, sticky W1C done flags, a maskable level interrupt, and self-clearing reset pulses. It sits between the AXI-Lite interconnect and the CORDIC/angle/Herzel datapath.

Parameters:
NF, 11, number of frequency channels (1..32)
FREQ_BA, 32'h1000_0000, base address of the freq array (RW, stride 4)
DATA_BA, 32'h2000_0000, base address of the result array (RO, stride 4)
VERSION, 32'h2904_2023, value returned by the VERSION register

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_awaddr  in  32  write address
s_awvalid / s_awready  in / out  1  write address handshake
s_wdata  in  32  write data
s_wstrb  in  4  write byte enables
s_wvalid / s_wready  in / out  1  write data handshake
s_bresp  out  2  00 = OKAY, 10 = SLVERR
s_bvalid / s_bready  out / in  1  write response handshake
s_araddr  in  32  read address
s_arvalid / s_arready  in / out  1  read address handshake
s_rdata  out  32  read data
s_rresp  out  2  00 = OKAY, 10 = SLVERR
s_rvalid / s_rready  out / in  1  read data handshake
freq_arr_o  out  NF×32  freq registers
data_arr_i  in  NF×32  Herzel results
valid_angel_i, valid_cordic_i  in  1  status inputs
valid_herzel_i  in  NF  per-channel result valid
num_samp_o, samp_freq_o  out  32  configuration
mode_o, en_cordic_o  out  1  configuration
reset_all_o, reset_h_o  out  1  one-cycle pulses
irq_o  out  1  level interrupt

Behaviour:
- Register map, offsets from 0:
  - 0x00 VERSION: RO.
  - 0x04 DEBUG: RW, reset F0F0_F0F0.
  - 0x08 MODE: RW, bit0.
  - 0x0C NUM_SAMP: RW, reset 0x0001_86A0.
  - 0x10 SAMP_FREQ: RW, reset 0x0003_0D40.
  - 0x14 EN_CORDIC: RW, bit0.
  - 0x18 STATUS: RO. bit0 = valid_angel_i, bit1 = valid_cordic_i, bit3 = &valid_herzel_i, other bits 0.
  - 0x1C CONTROL: WO. Writing bit0=1 pulses reset_all_o; writing bit1=1 pulses reset_h_o. Reads return 0.
  - 0x20 DONE: W1C, bits [NF-1:0].
  - 0x24 IRQ_EN: RW, bits [NF-1:0], reset 0.
  - FREQ_BA+4i: RW, reset 0.
  - DATA_BA+4i: RO snapshot.
- Unused bits of narrow registers read as 0.
- Decode errors return SLVERR with no side effect and rdata = 0. Error cases: unmapped address, addr[1:0] != 0, array index >= NF, write to an RO register, read of a WO register.
- Reset: all ready/valid outputs are 0, resp outputs are 00, registers take their reset values, and reset_*_o and irq_o are 0.
- Write FSM states: W_ADDR_DATA, W_DATA, W_ADDR, W_RESP.
  - s_awready and s_wready are high while the corresponding beat is not yet captured and bvalid is low.
  - AW and W may arrive in any order or in the same cycle.
  - The register updates in the cycle after both beats are captured; s_bvalid rises in that same cycle.
  - Only byte lanes with s_wstrb set are written.
  - s_bvalid and s_bresp hold until s_bready. No new AW/W is accepted while bvalid is high.
- Read FSM states: R_IDLE, R_DATA.
  - s_arready is high in R_IDLE.
  - On the arvalid&&arready handshake, rdata/rresp are registered and s_rvalid rises in the next cycle (latency 1).
  - rdata/rresp hold stable until s_rready.
- Read and write paths are independent. A read of a register written in the same cycle returns the old value.
- Result snapshot: prev_valid tracks valid_herzel_i. On a rising edge of bit i, data[i] <= data_arr_i[i] and DONE[i] <= 1.
- DONE set vs W1C clear in the same cycle: set wins.
- irq_o = |(DONE & IRQ_EN), registered, 1-cycle latency.
- CONTROL pulses last exactly one cycle, in the cycle after the write commits. Writing 0 produces no pulse.
- Reset mid-transaction aborts any in-flight handshake; after reset release the block waits for a fresh AW/W/AR.

Test Plan:
- Write 0x0C = 0x0000_1234 with strb 0xF, then read it back → bresp 00, rdata 0x0000_1234, num_samp_o = 0x1234; rvalid arrives 1 cycle after the AR handshake.
- W beat 3 cycles before AW beat, addr FREQ_BA+8, data 0xDEAD_BEEF, strb 0x3 → freq_arr_o[2] = 0x0000_BEEF, bvalid held until bready asserted 5 cycles later.
- Write FREQ_BA+4·NF (0x1000_002C), write 0x18, read 0x1C, read 0x3000_0000, read address 0x02 → all return SLVERR with no state change; read rdata = 0.
- IRQ_EN = 0x4, data_arr_i[2] = 0x55, rising edge on valid_herzel_i[2] → DATA_BA+8 reads 0x55, DONE = 0x4, irq_o = 1. A W1C of 0x4 in the same cycle as a new rising edge leaves DONE = 0x4; a later W1C with no edge clears irq_o.
- Write CONTROL = 0x3 → reset_all_o and reset_h_o high for exactly 1 cycle; a CONTROL read returns 0.
- Assert rstn low while bvalid = 1 → bvalid = 0, NUM_SAMP = 0x186A0, DEBUG = 0xF0F0_F0F0, irq_o = 0.
